// File: rtl/jtag_hub_reg_ctrl.sv
// rtl/jtag_hub_reg_ctrl.sv - jtag_hub slot command controller driving a req/ack register bus
module jtag_hub_reg_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              drck_in,
  input  logic              resetn_i,
  input  logic              sel_i,
  input  logic              capt_i,
  input  logic              shift_i,
  input  logic              tdi_i,
  output logic              tdo_o,
  output logic              req_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic              ack_i,
  output logic              busy_o
);

  localparam int FRAME_W = 2 + ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 2);
  localparam int TMR_W   = $clog2(TIMEOUT);

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_READ   = 2'b10;
  localparam logic [1:0] OP_STATUS = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [FRAME_W-1:0]  sr_q, sr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                shifting_q, shifting_d;
  logic                tout_err_q, tout_err_d;
  logic                len_err_q, len_err_d;
  logic                ovr_err_q, ovr_err_d;
  logic [DATA_W-1:0]   rb_q, rb_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;

  logic                busy;
  logic                do_capt;
  logic                do_shift;
  logic                eos;
  logic                frame_ok;
  logic [1:0]          op;
  logic [ADDR_W-1:0]   f_addr;
  logic [DATA_W-1:0]   f_data;
  logic                start_cmd;
  logic                ack_hit;
  logic                tmo_hit;
  logic [FRAME_W-1:0]  cap_frame;

  // Control decode: capture beats shift, end of shift is the first non-shifting cycle
  always_comb begin
    busy      = (state_q == ST_EXEC);
    do_capt   = sel_i & capt_i;
    do_shift  = sel_i & shift_i & ~capt_i;
    eos       = shifting_q & (~shift_i | ~sel_i);
    frame_ok  = eos & (cnt_q == CNT_W'(FRAME_W));
    op        = sr_q[1:0];
    f_addr    = sr_q[2 +: ADDR_W];
    f_data    = sr_q[2 + ADDR_W +: DATA_W];
    start_cmd = frame_ok & ~busy & ((op == OP_WRITE) | (op == OP_READ));
    ack_hit   = busy & ack_i;
    tmo_hit   = busy & ~ack_i & (tmr_q == TMR_W'(TIMEOUT - 1));
  end

  // Status frame presented to the host on capture
  always_comb begin
    cap_frame                = '0;
    cap_frame[0]             = busy;
    cap_frame[1]             = tout_err_q;
    cap_frame[2]             = len_err_q;
    cap_frame[3]             = ovr_err_q;
    cap_frame[4 +: DATA_W]   = rb_q;
  end

  // FSM state register
  always_ff @(posedge drck_in or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  // FSM next state: one bus transaction per accepted command, ack wins over timeout
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    case (state_q)
      ST_IDLE: begin
        if (start_cmd) begin
          state_d = ST_EXEC;
          tmr_d   = '0;
        end
      end
      ST_EXEC: begin
        if (ack_i) begin
          state_d = ST_IDLE;
        end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    req_o  = (state_q == ST_EXEC);
    busy_o = (state_q == ST_EXEC);
  end

  // Datapath next state: shift register, bit counter, sticky errors, bus fields
  always_comb begin
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    shifting_d = shifting_q;
    tout_err_d = tout_err_q;
    len_err_d  = len_err_q;
    ovr_err_d  = ovr_err_q;
    rb_d       = rb_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;

    if (do_capt) begin
      sr_d = cap_frame;
    end else if (do_shift) begin
      sr_d       = {tdi_i, sr_q[FRAME_W-1:1]};
      shifting_d = 1'b1;
      if (cnt_q != CNT_W'(FRAME_W + 1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if (eos) begin
      cnt_d      = '0;
      shifting_d = 1'b0;
      if (cnt_q != CNT_W'(FRAME_W)) begin
        len_err_d = 1'b1;
      end else if (busy) begin
        ovr_err_d = 1'b1;
      end else if ((op == OP_STATUS) && f_data[0]) begin
        tout_err_d = 1'b0;
        len_err_d  = 1'b0;
        ovr_err_d  = 1'b0;
      end
    end

    if (start_cmd) begin
      addr_d  = f_addr;
      wdata_d = f_data;
      we_d    = (op == OP_WRITE);
    end

    if (ack_hit && !we_q) begin
      rb_d = rdata_i;
    end

    if (tmo_hit) begin
      tout_err_d = 1'b1;
    end
  end

  // Datapath registers
  always_ff @(posedge drck_in or negedge resetn_i) begin
    if (!resetn_i) begin
      sr_q       <= '0;
      cnt_q      <= '0;
      shifting_q <= 1'b0;
      tout_err_q <= 1'b0;
      len_err_q  <= 1'b0;
      ovr_err_q  <= 1'b0;
      rb_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
    end else begin
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      shifting_q <= shifting_d;
      tout_err_q <= tout_err_d;
      len_err_q  <= len_err_d;
      ovr_err_q  <= ovr_err_d;
      rb_q       <= rb_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
    end
  end

  assign tdo_o   = sr_q[0];
  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;
  assign we_o    = we_q;

  // OP_NOP needs no action; named for readability of the decode above
  logic unused_nop;
  assign unused_nop = (op == OP_NOP);

endmodule

// File: tb/tb_jtag_hub_reg_ctrl.sv
// tb/tb_jtag_hub_reg_ctrl.sv - randomized and directed bench for jtag_hub_reg_ctrl
module tb_jtag_hub_reg_ctrl;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 64;
  localparam int FRAME_W = 2 + ADDR_W + DATA_W;

  logic        clk = 1'b0;
  logic        resetn;
  logic        sel, capt, shift, tdi;
  logic        tdo_o, req_o, we_o, busy_o;
  logic [7:0]  addr_o;
  logic [15:0] wdata_o;
  logic [15:0] rdata_i;
  logic        ack_i;
  logic        ack_man, ack_auto, auto_ack;
  logic [15:0] rdata_man, rdata_auto;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign ack_i   = ack_man | ack_auto;
  assign rdata_i = auto_ack ? rdata_auto : rdata_man;

  jtag_hub_reg_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .drck_in (clk),
    .resetn_i(resetn),
    .sel_i   (sel),
    .capt_i  (capt),
    .shift_i (shift),
    .tdi_i   (tdi),
    .tdo_o   (tdo_o),
    .req_o   (req_o),
    .we_o    (we_o),
    .addr_o  (addr_o),
    .wdata_o (wdata_o),
    .rdata_i (rdata_i),
    .ack_i   (ack_i),
    .busy_o  (busy_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Behavioural model: outgoing bits and incoming bits as plain queues,
  // a transaction flag with a cycle count, sticky flags and the bus fields.
  bit          oq[$];
  bit          iq[$];
  bit          m_exec;
  int          m_cyc;
  bit          m_tout, m_len, m_ovr, m_we;
  logic [15:0] m_rb, m_wdata, m_data;
  logic [7:0]  m_addr, m_fa;
  logic [1:0]  m_op;
  bit          m_ex, m_eos;

  function automatic bit status_bit(input int i, input bit bsy);
    if (i == 0) return bsy;
    if (i == 1) return m_tout;
    if (i == 2) return m_len;
    if (i == 3) return m_ovr;
    if (i >= 4 && i < 4 + DATA_W) return m_rb[i-4];
    return 1'b0;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      oq.delete();
      for (int i = 0; i < FRAME_W; i++) oq.push_back(1'b0);
      iq.delete();
      m_exec = 0; m_cyc = 0; m_tout = 0; m_len = 0; m_ovr = 0; m_we = 0;
      m_rb = '0; m_wdata = '0; m_addr = '0;
    end else begin
      m_ex  = m_exec;
      m_eos = (iq.size() > 0) && !(sel && shift);
      if (sel && capt) begin
        oq.delete();
        for (int i = 0; i < FRAME_W; i++) oq.push_back(status_bit(i, m_ex));
      end else if (sel && shift) begin
        void'(oq.pop_front());
        oq.push_back(tdi);
        iq.push_back(tdi);
      end
      if (m_eos) begin
        if (iq.size() != FRAME_W) begin
          m_len = 1;
        end else if (m_ex) begin
          m_ovr = 1;
        end else begin
          m_op = {iq[1], iq[0]};
          for (int k = 0; k < ADDR_W; k++) m_fa[k] = iq[2+k];
          for (int k = 0; k < DATA_W; k++) m_data[k] = iq[2+ADDR_W+k];
          if (m_op == 2'b11 && m_data[0]) begin
            m_tout = 0; m_len = 0; m_ovr = 0;
          end
          if (m_op == 2'b01 || m_op == 2'b10) begin
            m_exec = 1; m_cyc = 0;
            m_addr = m_fa; m_wdata = m_data; m_we = (m_op == 2'b01);
          end
        end
        iq.delete();
      end
      if (m_ex) begin
        if (ack_i) begin
          m_exec = 0;
          if (!m_we) m_rb = rdata_i;
        end else begin
          m_cyc++;
          if (m_cyc == TIMEOUT) begin
            m_exec = 0;
            m_tout = 1;
          end
        end
      end
    end
  end

  // Per-cycle compare of every output against the model
  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      chk("tdo", 64'(tdo_o), 64'(oq[0]));
      chk("req", 64'(req_o), 64'(m_exec));
      chk("busy", 64'(busy_o), 64'(m_exec));
      chk("we", 64'(we_o), 64'(m_we));
      chk("addr", 64'(addr_o), 64'(m_addr));
      chk("wdata", 64'(wdata_o), 64'(m_wdata));
    end
  end

  // Random bus responder, also fires stray acks while idle
  always @(negedge clk) begin
    if (auto_ack) begin
      ack_auto   = req_o ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
      rdata_auto = 16'($urandom);
    end else begin
      ack_auto = 1'b0;
    end
  end

  function automatic logic [63:0] make_frame(input logic [1:0] op, input logic [7:0] a,
                                             input logic [15:0] d);
    return {38'b0, d, a, op};
  endfunction

  task automatic shift_bits(input logic [63:0] v, input int n, output logic [63:0] outb);
    outb = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sel = 1; capt = 0; shift = 1; tdi = v[i];
      outb[i] = tdo_o;
    end
    @(negedge clk);
    shift = 0; tdi = 0;
  endtask

  task automatic capture();
    @(negedge clk);
    sel = 1; capt = 1; shift = 0;
    @(negedge clk);
    capt = 0;
  endtask

  task automatic read_status(output logic [63:0] st);
    logic [63:0] o;
    capture();
    shift_bits(make_frame(2'b00, 8'h00, 16'h0000), FRAME_W, o);
    st = o & ((64'd1 << FRAME_W) - 1);
  endtask

  task automatic clear_errors();
    logic [63:0] o;
    shift_bits(make_frame(2'b11, 8'h00, 16'h0001), FRAME_W, o);
  endtask

  task automatic pulse_ack(input logic [15:0] rd);
    ack_man = 1; rdata_man = rd;
    @(negedge clk);
    ack_man = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] st, o;
    int n, kind, len;
    resetn = 0; sel = 0; capt = 0; shift = 0; tdi = 0;
    ack_man = 0; ack_auto = 0; auto_ack = 0; rdata_man = '0; rdata_auto = '0;
    repeat (3) @(negedge clk);
    chk("rst_req", 64'(req_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_tdo", 64'(tdo_o), 64'd0);
    chk("rst_addr", 64'(addr_o), 64'd0);
    chk("rst_wdata", 64'(wdata_o), 64'd0);
    resetn = 1;

    // write with ack three cycles later
    shift_bits(make_frame(2'b01, 8'h12, 16'hABCD), FRAME_W, o);
    @(negedge clk);
    chk("wr_req", 64'(req_o), 64'd1);
    chk("wr_we", 64'(we_o), 64'd1);
    chk("wr_addr", 64'(addr_o), 64'h12);
    chk("wr_wdata", 64'(wdata_o), 64'hABCD);
    repeat (2) @(negedge clk);
    pulse_ack(16'h0000);
    chk("wr_req_drop", 64'(req_o), 64'd0);
    chk("wr_busy_drop", 64'(busy_o), 64'd0);

    // read with data returned
    shift_bits(make_frame(2'b10, 8'h34, 16'h0000), FRAME_W, o);
    @(negedge clk);
    chk("rd_we", 64'(we_o), 64'd0);
    pulse_ack(16'h5A5A);
    read_status(st);
    chk("rd_flags", st[3:0], 64'h0);
    chk("rd_data", 64'(st[19:4]), 64'h5A5A);

    // timeout
    shift_bits(make_frame(2'b10, 8'h56, 16'h0000), FRAME_W, o);
    n = 0;
    @(negedge clk);
    while (req_o && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("tmo_width", 64'(n), 64'd64);
    read_status(st);
    chk("tmo_flag", 64'(st[1]), 64'd1);
    chk("tmo_rb_kept", 64'(st[19:4]), 64'h5A5A);
    clear_errors();
    read_status(st);
    chk("tmo_cleared", st[3:0], 64'h0);

    // length error
    shift_bits(make_frame(2'b01, 8'h21, 16'h1111), FRAME_W - 1, o);
    @(negedge clk);
    chk("len_noreq", 64'(req_o), 64'd0);
    read_status(st);
    chk("len_flag", 64'(st[2]), 64'd1);
    clear_errors();

    // overrun: second write while first in flight
    shift_bits(make_frame(2'b01, 8'h77, 16'h1234), FRAME_W, o);
    shift_bits(make_frame(2'b01, 8'h88, 16'h4321), FRAME_W, o);
    @(negedge clk);
    chk("ovr_req", 64'(req_o), 64'd1);
    chk("ovr_addr", 64'(addr_o), 64'h77);
    pulse_ack(16'h0000);
    chk("ovr_done", 64'(req_o), 64'd0);
    read_status(st);
    chk("ovr_flag", 64'(st[3]), 64'd1);
    clear_errors();

    // ack on the timeout edge
    shift_bits(make_frame(2'b10, 8'h9A, 16'h0000), FRAME_W, o);
    repeat (64) @(negedge clk);
    pulse_ack(16'hC3C3);
    chk("col_req", 64'(req_o), 64'd0);
    read_status(st);
    chk("col_tmo", 64'(st[1]), 64'd0);
    chk("col_data", 64'(st[19:4]), 64'hC3C3);

    // reset mid transaction
    shift_bits(make_frame(2'b01, 8'hAA, 16'h5555), FRAME_W, o);
    repeat (5) @(negedge clk);
    chk("mid_req", 64'(req_o), 64'd1);
    #2 resetn = 0;
    #1;
    chk("arst_req", 64'(req_o), 64'd0);
    chk("arst_busy", 64'(busy_o), 64'd0);
    chk("arst_addr", 64'(addr_o), 64'd0);
    chk("arst_wdata", 64'(wdata_o), 64'd0);
    chk("arst_we", 64'(we_o), 64'd0);
    @(negedge clk);
    resetn = 1;
    read_status(st);
    chk("arst_frame", st, 64'd0);

    // random traffic against the model
    auto_ack = 1;
    for (int t = 0; t < 80; t++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 4) begin
        shift_bits(make_frame(2'($urandom), 8'($urandom), 16'($urandom)), FRAME_W, o);
      end else if (kind == 5) begin
        len = $urandom_range(FRAME_W - 4, FRAME_W + 4);
        shift_bits(make_frame(2'($urandom), 8'($urandom), 16'($urandom)), len, o);
      end else if (kind <= 7) begin
        read_status(st);
      end else if (kind == 8) begin
        sel = $urandom_range(0, 1);
        repeat ($urandom_range(1, 20)) @(negedge clk);
      end else begin
        len = $urandom_range(1, FRAME_W - 1);
        for (int i = 0; i < len; i++) begin
          @(negedge clk);
          sel = 1; capt = 0; shift = 1; tdi = 1'($urandom);
        end
        @(negedge clk);
        sel = 0;
        @(negedge clk);
        shift = 0;
      end
    end
    auto_ack = 0;
    n = 0;
    while (req_o && n < 200) begin
      n++;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/jtag_hub_reg_ctrl.md
# jtag_hub_reg_ctrl

Per-slot command controller between one jtag_hub user-app port and a small user register bus. It shifts a fixed-length command frame in from the hub and returns a status/readback frame. It decodes the frame and sequences exactly one bus read or write with req/ack handshake and timeout. One instance sits on each hub slot that needs host-side register access.

## Interface
Parameters:
- ADDR_W, 8, bus address width (≥2)
- DATA_W, 16, bus data width
- TIMEOUT, 64, max cycles req_o stays high without ack_i (≥2)
- FRAME_W derived: 2+ADDR_W+DATA_W (26 at defaults)

Ports:
- drck_in  input  1  clock (hub drck_o, TCK domain); one clock, all logic on rising edge
- resetn_i  input  1  asynchronous active-low reset
- sel_i  input  1  this slot's conf_sel bit
- capt_i  input  1  hub capt_o
- shift_i  input  1  hub shift_o
- tdi_i  input  1  hub_tdi
- tdo_o  output  1  to this slot's hub_tdo bit
- req_o  output  1  bus request
- we_o  output  1  1 = write, 0 = read
- addr_o  output  ADDR_W  bus address
- wdata_o  output  DATA_W  write data
- rdata_i  input  DATA_W  read data, valid with ack_i
- ack_i  input  1  bus acknowledge, single cycle
- busy_o  output  1  bus transaction in flight

## Operation
Shift register sr[FRAME_W-1:0] layout:
- sr[1:0] is op: 00 nop, 01 write, 10 read, 11 status.
- sr[2 +: ADDR_W] is addr.
- sr[2+ADDR_W +: DATA_W] is data.

Shifting is LSB first; op bits enter first.

Capture (sel_i & capt_i), sr loads:
- [0] busy
- [1] timeout error
- [2] length error
- [3] overrun error
- [4 +: DATA_W] last read data
- remaining bits 0

Shift (sel_i & shift_i):
- sr <= {tdi_i, sr[FRAME_W-1:1]}.
- tdo_o = sr[0] (register bit).
- Bit counter increments, saturating at FRAME_W+1.
- shifting flag is set.

End of shift is the first cycle with shifting flag set and (!shift_i | !sel_i). Counter and flag clear. Then, in priority order:
- Count ≠ FRAME_W: length error set; no decode.
- busy: overrun error set; command dropped.
- op 00: nothing.
- op 11: if data bit0 = 1, clear all three sticky errors.
- op 01/10: load addr_o, wdata_o (data field), we_o; enter EXEC.

FSM states:
- IDLE: capture, shift and decode as above.
- EXEC: req_o=1, busy_o=1; addr_o/we_o/wdata_o held stable.
  - On ack_i=1: read latches rdata_i into readback register → IDLE.
  - After TIMEOUT cycles without ack: timeout error set, readback unchanged → IDLE.
- Capture and shift remain operational in EXEC; frames decoded in EXEC take the overrun path.
- ack_i outside EXEC is ignored.
- Capture and shift asserted in the same cycle: capture wins, no shift.

## Timing
- Reset values: tdo_o 0, req_o 0, we_o 0, addr_o 0, wdata_o 0, busy_o 0, sr 0, errors 0, readback 0, state IDLE.
- tdo_o shows sr[0] one cycle after capture edge; each shift edge presents the next bit.
- End-of-shift detect edge E: req_o and busy_o high after E (latency 1 from end of shift).
- ack_i sampled high at edge A: req_o/busy_o low after A; readback valid after A. Minimum req_o width is 1 cycle (ack at first EXEC edge).
- Timeout: req_o high exactly TIMEOUT cycles, then low with timeout error set on the same edge.
- ack_i on the same edge as timeout expiry: ack wins, no error.
- resetn_i low mid-shift or mid-EXEC: everything returns to reset values immediately (asynchronous). req_o drops without waiting for ack.
- sel_i dropping mid-shift counts as end of shift and yields a length error if count < FRAME_W.

## Test plan
- Write: shift 26 bits {16'hABCD, 8'h12, 2'b01} → req_o=1, we_o=1, addr_o=8'h12, wdata_o=16'hABCD one cycle after end of shift. Ack after 3 cycles → req_o low next cycle, busy_o low.
- Read: frame {16'h0, 8'h34, 2'b10}, ack with rdata_i=16'h5A5A. Next capture+shift returns bits[3:0]=0000 and bits[19:4]=16'h5A5A.
- Timeout: read with no ack → req_o high exactly 64 cycles. Capture reads bit1=1, readback unchanged. Status frame with data bit0=1 clears bit1.
- Length/overrun: shift 25 bits → no req, bit2=1. During EXEC, shift a valid write → bit3=1, no second request, first transaction completes normally.
- Reset mid-EXEC: pull resetn_i low while req_o=1 → all outputs 0 immediately. After release, capture returns all-zero frame.
- Ack/timeout collision: ack_i on cycle 64 of EXEC → data latched, bit1 stays 0.
